fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/fifo_wr_arb.sv | 91 +++++++++
 tb/tb_fifo_wr_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and default sizing for the arbitrated FIFO
//               write front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int C_DEFAULT_SIZE      = 4;
    localparam int C_DEFAULT_DWIDTH    = 8;
    localparam int C_DEFAULT_AF_THRESH = 9;

    // Names the producer that wins when both request in the same cycle.
    typedef enum logic [0:0] {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with combinational grants and a
//               registered priority state.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic enable,
    output logic gnt0,
    output logic gnt1
);

    arb_state_t r_state;
    logic       w_allow;

    // Reset also masks grants so nothing is accepted in the reset cycle.
    assign w_allow = enable & ~rst;
    assign gnt0    = w_allow & req0 & (~req1 | (r_state == PRI0));
    assign gnt1    = w_allow & req1 & (~req0 | (r_state == PRI1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PRI0;
        end else if (gnt0) begin
            r_state <= PRI1;
        end else if (gnt1) begin
            r_state <= PRI0;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb
// Description : Two-producer FIFO write arbiter with pointer, occupancy and
//               status flag generation for an external memory.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int SIZE      = C_DEFAULT_SIZE,
    parameter int DWIDTH    = C_DEFAULT_DWIDTH,
    parameter int AF_THRESH = C_DEFAULT_AF_THRESH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DWIDTH-1:0] data0,
    input  logic [DWIDTH-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              rd_en,
    output logic              rd_ack,
    output logic              w_en,
    output logic [DWIDTH-1:0] w_data,
    output logic [SIZE-1:0]   w_pointer,
    output logic [SIZE-1:0]   r_pointer,
    output logic [SIZE:0]     count,
    output logic              full,
    output logic              empty,
    output logic              a_flag
);

    localparam logic [SIZE:0] C_FULL_COUNT = {1'b1, {SIZE{1'b0}}};
    localparam logic [SIZE:0] C_AF_COUNT   = AF_THRESH[SIZE:0];

    logic [SIZE-1:0] r_wr_ptr;
    logic [SIZE-1:0] r_rd_ptr;
    logic [SIZE:0]   r_count;
    logic            w_cnt_full;
    logic            w_cnt_empty;

    assign w_cnt_full  = (r_count == C_FULL_COUNT);
    assign w_cnt_empty = (r_count == '0);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .enable (~w_cnt_full),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    assign w_en   = gnt0 | gnt1;
    assign w_data = gnt0 ? data0 : (gnt1 ? data1 : '0);
    assign rd_ack = rd_en & ~w_cnt_empty & ~rst;

    // Flags read as "reset" during the reset cycle, before count has cleared.
    assign empty  = w_cnt_empty | rst;
    assign full   = w_cnt_full & ~rst;
    assign a_flag = (r_count > C_AF_COUNT) & ~rst;

    assign w_pointer = r_wr_ptr;
    assign r_pointer = r_rd_ptr;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (rd_ack) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_en, rd_ack})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fifo_wr_arb
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arb
// Description : Self-checking bench for fifo_wr_arb against a queue-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rd_en = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       gnt0, gnt1, rd_ack, w_en, full, empty, a_flag;
    logic [7:0] w_data;
    logic [3:0] w_pointer, r_pointer;
    logic [4:0] count;

    fifo_wr_arb dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .rd_en(rd_en), .rd_ack(rd_ack), .w_en(w_en), .w_data(w_data),
        .w_pointer(w_pointer), .r_pointer(r_pointer), .count(count),
        .full(full), .empty(empty), .a_flag(a_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stored words, total writes/reads, favoured producer.
    logic [7:0] m_q[$];
    int         m_writes = 0;
    int         m_reads  = 0;
    int         m_fav    = 0;

    // Snapshot of one cycle: observed and model-expected outputs.
    logic [27:0] obs_v, exp_v;
    logic        s_g0, s_g1, s_ack, s_full, s_empty, s_af;
    logic [3:0]  s_wp, s_rp;
    logic [4:0]  s_count;

    task automatic step(input logic r0, input logic r1, input logic [7:0] d0,
                        input logic [7:0] d1, input logic rd, input logic rs);
        logic e_g0, e_g1, e_ack, e_full, e_empty, e_af;
        logic [7:0] e_wd;
        int occ;
        @(negedge clk);
        req0 = r0; req1 = r1; data0 = d0; data1 = d1; rd_en = rd; rst = rs;
        #1;
        s_g0 = gnt0; s_g1 = gnt1; s_ack = rd_ack; s_full = full;
        s_empty = empty; s_af = a_flag; s_wp = w_pointer; s_rp = r_pointer;
        s_count = count;
        obs_v = {gnt0, gnt1, rd_ack, w_en, w_data, w_pointer, r_pointer,
                 count, full, empty, a_flag};
        occ = m_q.size();
        if (rs) begin
            e_g0 = 0; e_g1 = 0; e_ack = 0;
            e_full = 0; e_empty = 1; e_af = 0;
        end else begin
            e_full  = (occ == 16);
            e_empty = (occ == 0);
            e_af    = (occ > 9);
            e_g0    = !e_full && r0 && (!r1 || m_fav == 0);
            e_g1    = !e_full && r1 && (!r0 || m_fav == 1);
            e_ack   = rd && occ > 0;
        end
        e_wd  = e_g0 ? d0 : (e_g1 ? d1 : 8'h00);
        exp_v = {e_g0, e_g1, e_ack, e_g0 | e_g1, e_wd, 4'(m_writes % 16),
                 4'(m_reads % 16), 5'(occ), e_full, e_empty, e_af};
        @(posedge clk);
        if (rs) begin
            m_q.delete(); m_writes = 0; m_reads = 0; m_fav = 0;
        end else begin
            if (e_ack) begin void'(m_q.pop_front()); m_reads++; end
            if (e_g0) begin m_q.push_back(d0); m_writes++; m_fav = 1; end
            if (e_g1) begin m_q.push_back(d1); m_writes++; m_fav = 0; end
        end
    endtask

    task automatic test_reset();
        step(1, 1, 8'h11, 8'h22, 1, 1);
        n_checks++;
        if (s_g0 !== 0 || s_g1 !== 0 || s_ack !== 0) begin
            n_errors++;
            $display("FAIL reset_grants: got g0=%b g1=%b ack=%b, want all 0", s_g0, s_g1, s_ack);
        end
        step(0, 0, 8'h00, 8'h00, 0, 0);
        n_checks++;
        if (s_count !== 0 || s_wp !== 0 || s_rp !== 0 || s_empty !== 1 || s_full !== 0 || s_af !== 0) begin
            n_errors++;
            $display("FAIL reset_state: got count=%0d wp=%0d rp=%0d e=%b f=%b af=%b, want 0 0 0 1 0 0",
                     s_count, s_wp, s_rp, s_empty, s_full, s_af);
        end
    endtask

    task automatic test_alternation();
        logic [3:0] pat = 4'b1010;  // gnt0 expected on cycles 0 and 2
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 8'(8'hA0 + i), 8'(8'hB0 + i), 0, 0);
            n_checks++;
            if (s_g0 !== pat[3-i] || s_g1 !== !pat[3-i] || obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL alternation[%0d]: got g0=%b g1=%b obs=%h, want g0=%b obs=%h",
                         i, s_g0, s_g1, obs_v, pat[3-i], exp_v);
            end
        end
        step(0, 0, 8'h00, 8'h00, 0, 0);
        n_checks++;
        if (s_count !== 4 || s_wp !== 4) begin
            n_errors++;
            $display("FAIL alternation_count: got count=%0d wp=%0d, want 4 4", s_count, s_wp);
        end
    endtask

    task automatic test_fill();
        step(0, 0, 8'h00, 8'h00, 0, 1);
        for (int k = 0; k < 16; k++) begin
            step(1, 0, 8'($urandom), 8'h00, 0, 0);
            n_checks++;
            if (s_g0 !== 1 || s_count !== 5'(k) || s_af !== (k >= 10) || obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL fill[%0d]: got g0=%b count=%0d af=%b obs=%h, want exp=%h",
                         k, s_g0, s_count, s_af, obs_v, exp_v);
            end
        end
        step(1, 0, 8'h55, 8'h00, 0, 0);
        n_checks++;
        if (s_g0 !== 0 || s_full !== 1 || s_count !== 16 || s_af !== 1) begin
            n_errors++;
            $display("FAIL fill_full: got g0=%b full=%b count=%0d af=%b, want 0 1 16 1",
                     s_g0, s_full, s_count, s_af);
        end
    endtask

    task automatic test_full_read();
        step(0, 1, 8'h00, 8'h77, 1, 0);
        n_checks++;
        if (s_ack !== 1 || s_g1 !== 0 || s_full !== 1) begin
            n_errors++;
            $display("FAIL full_read: got ack=%b g1=%b full=%b, want 1 0 1", s_ack, s_g1, s_full);
        end
        step(0, 1, 8'h00, 8'h78, 1, 0);
        n_checks++;
        if (s_count !== 15 || s_g1 !== 1 || s_ack !== 1 || obs_v !== exp_v) begin
            n_errors++;
            $display("FAIL full_read_next: got count=%0d g1=%b ack=%b, want 15 1 1", s_count, s_g1, s_ack);
        end
        step(0, 0, 8'h00, 8'h00, 0, 0);
        n_checks++;
        if (s_count !== 15) begin
            n_errors++;
            $display("FAIL full_read_hold: got count=%0d, want 15", s_count);
        end
    endtask

    task automatic test_empty_rw();
        step(0, 0, 8'h00, 8'h00, 0, 1);
        step(1, 0, 8'h3C, 8'h00, 1, 0);
        n_checks++;
        if (s_ack !== 0 || s_g0 !== 1 || w_data !== 8'h3C) begin
            n_errors++;
            $display("FAIL empty_rw: got ack=%b g0=%b wdata=%h, want 0 1 3c", s_ack, s_g0, w_data);
        end
        step(0, 0, 8'h00, 8'h00, 0, 0);
        n_checks++;
        if (s_count !== 1 || s_rp !== 0 || s_wp !== 1) begin
            n_errors++;
            $display("FAIL empty_rw_state: got count=%0d rp=%0d wp=%0d, want 1 0 1", s_count, s_rp, s_wp);
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 8'h00, 8'h00, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 8'($urandom), 8'h00, 0, 0);
            step(0, 0, 8'h00, 8'h00, 1, 0);
            n_checks++;
            if (s_ack !== 1 || obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL wrap[%0d]: got obs=%h, want %h", i, obs_v, exp_v);
            end
        end
        step(0, 0, 8'h00, 8'h00, 0, 0);
        n_checks++;
        if (s_wp !== 4 || s_rp !== 4 || s_count !== 0 || s_empty !== 1) begin
            n_errors++;
            $display("FAIL wrap_end: got wp=%0d rp=%0d count=%0d empty=%b, want 4 4 0 1",
                     s_wp, s_rp, s_count, s_empty);
        end
    endtask

    task automatic test_mid_reset();
        step(0, 0, 8'h00, 8'h00, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 8'($urandom), 0, 0);
        step(1, 1, 8'h01, 8'h02, 0, 1);
        n_checks++;
        if (s_g0 !== 0 || s_g1 !== 0 || s_count !== 7) begin
            n_errors++;
            $display("FAIL mid_reset_grant: got g0=%b g1=%b count=%0d, want 0 0 7", s_g0, s_g1, s_count);
        end
        step(1, 1, 8'h03, 8'h04, 0, 0);
        n_checks++;
        if (s_count !== 0 || s_wp !== 0 || s_rp !== 0 || s_g0 !== 1 || s_g1 !== 0) begin
            n_errors++;
            $display("FAIL mid_reset_after: got count=%0d wp=%0d rp=%0d g0=%b g1=%b, want 0 0 0 1 0",
                     s_count, s_wp, s_rp, s_g0, s_g1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int rd_pct = (i < 200) ? 30 : 70;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom),
                 $urandom_range(0, 99) < rd_pct, $urandom_range(0, 79) == 0);
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL random[%0d]: got obs=%h, want %h", i, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_fill();
        test_full_read();
        test_empty_rw();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_wr_arb
`default_nettype wire
